// File: rtl/teachee_led_pkg.sv
// Shared types for the TEACHEE status LED controller: blink patterns and display states.
package teachee_led_pkg;

  typedef enum logic [1:0] {
    PAT_OFF   = 2'd0,
    PAT_SOLID = 2'd1,
    PAT_SLOW  = 2'd2,
    PAT_FAST  = 2'd3
  } pattern_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a registered
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          levelPrev_q;
  logic          rise_q, rise_d;

  // The counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = level_q & ~levelPrev_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      levelPrev_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn};
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      levelPrev_q <= level_q;
      rise_q      <= rise_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/led_status_controller.sv
// Drives the two TEACHEE status LEDs from sticky, prioritized requester events;
// a debounced button acknowledges the event currently on display.
module led_status_controller
  import teachee_led_pkg::*;
#(
  parameter int CLK_HZ          = 12_000_000,
  parameter int NUM_REQ         = 4,
  parameter int SLOW_HZ         = 1,
  parameter int FAST_HZ         = 5,
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic                       sysclk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_set,
  input  logic [2*NUM_REQ-1:0]       req_pattern,
  input  logic                       btn,
  output logic                       TEACHEE_LED0,
  output logic                       TEACHEE_LED1,
  output logic [NUM_REQ-1:0]         pending,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       btn_press
);

  localparam int HALF_SLOW = CLK_HZ / (2 * SLOW_HZ);
  localparam int HALF_FAST = CLK_HZ / (2 * FAST_HZ);
  localparam int CW        = $clog2(HALF_SLOW);
  localparam int GW        = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d, clrMask;
  pattern_t           pat_q [NUM_REQ];
  pattern_t           pat_d [NUM_REQ];
  logic [GW-1:0]      grant_q, grant_d;
  logic [CW-1:0]      cnt_q, cnt_d, halfM1;
  logic               phase_q, phase_d;
  logic               led0_q, led0_d, led1_q, led1_d;
  logic               blink, restart;
  pattern_t           curPat;
  logic               btnRise;
  logic               unused_btn_level;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .btn       (btn),
    .level     (unused_btn_level),
    .rise_pulse(btnRise)
  );

  // A set in the same cycle as an acknowledge of that index wins.
  always_comb begin
    clrMask = '0;
    if (btnRise && state_q == ST_SHOW) clrMask[grant_q] = 1'b1;
    pending_d = (pending_q & ~clrMask) | req_set;
    pat_d = pat_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_set[i]) pat_d[i] = pattern_t'(req_pattern[2*i +: 2]);
    end
  end

  always_comb begin
    grant_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) grant_d = GW'(i);
    end
    state_d = (|pending_q) ? ST_SHOW : ST_IDLE;
  end

  // Any change of state or winner restarts the blink; a count already past a
  // shorter half-period wraps at once instead of running on.
  always_comb begin
    curPat  = pat_q[grant_d];
    blink   = (state_d == ST_IDLE) || (curPat == PAT_SLOW) || (curPat == PAT_FAST);
    halfM1  = (state_d == ST_SHOW && curPat == PAT_FAST) ? CW'(HALF_FAST - 1) : CW'(HALF_SLOW - 1);
    restart = (state_d != state_q) || (state_d == ST_SHOW && grant_d != grant_q);
    cnt_d   = '0;
    phase_d = (state_d == ST_SHOW);
    if (!restart && blink) begin
      if (cnt_q >= halfM1) begin
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
      end
    end
    if (state_d == ST_IDLE) begin
      led0_d = phase_d;
      led1_d = ~phase_d;
    end else begin
      case (curPat)
        PAT_OFF:   led0_d = 1'b0;
        PAT_SOLID: led0_d = 1'b1;
        default:   led0_d = phase_d;
      endcase
      led1_d = |(pending_q & (pending_q - NUM_REQ'(1)));
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      pat_q     <= '{default: PAT_OFF};
      grant_q   <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      led0_q    <= 1'b0;
      led1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pat_q     <= pat_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      led0_q    <= led0_d;
      led1_q    <= led1_d;
    end
  end

  assign TEACHEE_LED0 = led0_q;
  assign TEACHEE_LED1 = led1_q;
  assign pending      = pending_q;
  assign grant_valid  = (state_q == ST_SHOW);
  assign grant_id     = grant_q;
  assign btn_press    = btnRise;

endmodule

// File: tb/tb_led_status_controller.sv
// Directed self-checking bench for led_status_controller with shortened timing
// (HALF_SLOW=500, HALF_FAST=100, DEBOUNCE_CYCLES=4).
module tb_led_status_controller;

  logic       sysclk;
  logic       reset_n;
  logic [3:0] req_set;
  logic [7:0] req_pattern;
  logic       btn;
  logic       TEACHEE_LED0;
  logic       TEACHEE_LED1;
  logic [3:0] pending;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       btn_press;

  int checks;
  int failures;

  led_status_controller #(
    .CLK_HZ(1000),
    .NUM_REQ(4),
    .SLOW_HZ(1),
    .FAST_HZ(5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .sysclk      (sysclk),
    .reset_n     (reset_n),
    .req_set     (req_set),
    .req_pattern (req_pattern),
    .btn         (btn),
    .TEACHEE_LED0(TEACHEE_LED0),
    .TEACHEE_LED1(TEACHEE_LED1),
    .pending     (pending),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .btn_press   (btn_press)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) tick();
    checks++; if (TEACHEE_LED0 !== 1'b0) begin failures++; $display("[TB] FAIL rst_led0 got=%b want=0", TEACHEE_LED0); end
    checks++; if (TEACHEE_LED1 !== 1'b0) begin failures++; $display("[TB] FAIL rst_led1 got=%b want=0", TEACHEE_LED1); end
    checks++; if (pending !== 4'b0000) begin failures++; $display("[TB] FAIL rst_pending got=%b want=0000", pending); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_gvalid got=%b want=0", grant_valid); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("[TB] FAIL rst_gid got=%0d want=0", grant_id); end
    checks++; if (btn_press !== 1'b0) begin failures++; $display("[TB] FAIL rst_press got=%b want=0", btn_press); end
    reset_n = 1'b1;
    tick();
    checks++; if (TEACHEE_LED0 !== 1'b0) begin failures++; $display("[TB] FAIL rel_led0 got=%b want=0", TEACHEE_LED0); end
    checks++; if (TEACHEE_LED1 !== 1'b1) begin failures++; $display("[TB] FAIL rel_led1 got=%b want=1", TEACHEE_LED1); end
  endtask

  task automatic test_idle();
    repeat (249) tick();
    checks++; if ({TEACHEE_LED0, TEACHEE_LED1} !== 2'b01) begin failures++; $display("[TB] FAIL idle_ph0 got=%b want=01", {TEACHEE_LED0, TEACHEE_LED1}); end
    repeat (500) tick();
    checks++; if ({TEACHEE_LED0, TEACHEE_LED1} !== 2'b10) begin failures++; $display("[TB] FAIL idle_ph1 got=%b want=10", {TEACHEE_LED0, TEACHEE_LED1}); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_gvalid got=%b want=0", grant_valid); end
  endtask

  task automatic test_single_fast();
    req_set = 4'b0100;
    req_pattern = 8'h30;
    tick();
    req_set = 4'b0000;
    req_pattern = 8'h00;
    checks++; if (pending !== 4'b0100) begin failures++; $display("[TB] FAIL fast_pending got=%b want=0100", pending); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("[TB] FAIL fast_gvalid_early got=%b want=0", grant_valid); end
    tick();
    checks++; if (grant_valid !== 1'b1) begin failures++; $display("[TB] FAIL fast_gvalid got=%b want=1", grant_valid); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("[TB] FAIL fast_gid got=%0d want=2", grant_id); end
    checks++; if ({TEACHEE_LED0, TEACHEE_LED1} !== 2'b10) begin failures++; $display("[TB] FAIL fast_start got=%b want=10", {TEACHEE_LED0, TEACHEE_LED1}); end
    repeat (99) tick();
    checks++; if (TEACHEE_LED0 !== 1'b1) begin failures++; $display("[TB] FAIL fast_on_end got=%b want=1", TEACHEE_LED0); end
    tick();
    checks++; if (TEACHEE_LED0 !== 1'b0) begin failures++; $display("[TB] FAIL fast_off_start got=%b want=0", TEACHEE_LED0); end
    repeat (99) tick();
    checks++; if (TEACHEE_LED0 !== 1'b0) begin failures++; $display("[TB] FAIL fast_off_end got=%b want=0", TEACHEE_LED0); end
    tick();
    checks++; if (TEACHEE_LED0 !== 1'b1) begin failures++; $display("[TB] FAIL fast_on_again got=%b want=1", TEACHEE_LED0); end
  endtask

  task automatic test_preemption();
    req_set = 4'b0001;
    req_pattern = 8'h01;
    tick();
    req_set = 4'b0000;
    req_pattern = 8'h00;
    checks++; if (pending !== 4'b0101) begin failures++; $display("[TB] FAIL pre_pending got=%b want=0101", pending); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("[TB] FAIL pre_gid_early got=%0d want=2", grant_id); end
    tick();
    checks++; if (grant_id !== 2'd0) begin failures++; $display("[TB] FAIL pre_gid got=%0d want=0", grant_id); end
    checks++; if ({TEACHEE_LED0, TEACHEE_LED1} !== 2'b11) begin failures++; $display("[TB] FAIL pre_leds got=%b want=11", {TEACHEE_LED0, TEACHEE_LED1}); end
    repeat (150) tick();
    checks++; if (TEACHEE_LED0 !== 1'b1) begin failures++; $display("[TB] FAIL pre_solid got=%b want=1", TEACHEE_LED0); end
  endtask

  task automatic test_button_ack();
    int presses = 0;
    int firstPress = -1;
    for (int i = 0; i < 20; i++) begin
      btn = (i < 10);
      tick();
      if (btn_press === 1'b1) begin
        presses++;
        if (firstPress < 0) firstPress = i;
      end
    end
    checks++; if (presses != 1) begin failures++; $display("[TB] FAIL ack_presses got=%0d want=1", presses); end
    checks++; if (firstPress != 6) begin failures++; $display("[TB] FAIL ack_latency got=%0d want=6", firstPress); end
    checks++; if (pending !== 4'b0100) begin failures++; $display("[TB] FAIL ack_pending got=%b want=0100", pending); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("[TB] FAIL ack_gid got=%0d want=2", grant_id); end
    checks++; if ({TEACHEE_LED0, TEACHEE_LED1} !== 2'b10) begin failures++; $display("[TB] FAIL ack_leds got=%b want=10", {TEACHEE_LED0, TEACHEE_LED1}); end
    repeat (88) tick();
    checks++; if (TEACHEE_LED0 !== 1'b1) begin failures++; $display("[TB] FAIL ack_on_end got=%b want=1", TEACHEE_LED0); end
    tick();
    checks++; if (TEACHEE_LED0 !== 1'b0) begin failures++; $display("[TB] FAIL ack_off got=%b want=0", TEACHEE_LED0); end
  endtask

  task automatic test_glitch();
    int presses = 0;
    for (int i = 0; i < 12; i++) begin
      btn = (i < 3);
      tick();
      if (btn_press === 1'b1) presses++;
    end
    checks++; if (presses != 0) begin failures++; $display("[TB] FAIL glitch_presses got=%0d want=0", presses); end
    checks++; if (pending !== 4'b0100) begin failures++; $display("[TB] FAIL glitch_pending got=%b want=0100", pending); end
  endtask

  task automatic test_simultaneous();
    int presses = 0;
    for (int i = 0; i < 20; i++) begin
      btn = (i < 10);
      req_set = 4'b0000;
      if (btn_press === 1'b1) begin
        req_set = 4'b0100;
        req_pattern = 8'h20;
      end
      tick();
      if (btn_press === 1'b1) presses++;
    end
    req_set = 4'b0000;
    req_pattern = 8'h00;
    checks++; if (presses != 1) begin failures++; $display("[TB] FAIL sim_presses got=%0d want=1", presses); end
    checks++; if (pending !== 4'b0100) begin failures++; $display("[TB] FAIL sim_pending got=%b want=0100", pending); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("[TB] FAIL sim_gid got=%0d want=2", grant_id); end
    checks++; if (TEACHEE_LED0 !== 1'b0) begin failures++; $display("[TB] FAIL sim_led0 got=%b want=0", TEACHEE_LED0); end
    repeat (200) tick();
    checks++; if (TEACHEE_LED0 !== 1'b0) begin failures++; $display("[TB] FAIL sim_slow_hold got=%b want=0", TEACHEE_LED0); end
    repeat (267) tick();
    checks++; if (TEACHEE_LED0 !== 1'b0) begin failures++; $display("[TB] FAIL sim_slow_end got=%b want=0", TEACHEE_LED0); end
    tick();
    checks++; if (TEACHEE_LED0 !== 1'b1) begin failures++; $display("[TB] FAIL sim_slow_wrap got=%b want=1", TEACHEE_LED0); end
  endtask

  task automatic test_reset_mid();
    req_set = 4'b1001;
    req_pattern = 8'h43;
    tick();
    req_set = 4'b0000;
    req_pattern = 8'h00;
    checks++; if (pending !== 4'b1101) begin failures++; $display("[TB] FAIL mid_pending got=%b want=1101", pending); end
    tick();
    checks++; if (grant_id !== 2'd0) begin failures++; $display("[TB] FAIL mid_gid got=%0d want=0", grant_id); end
    checks++; if ({TEACHEE_LED0, TEACHEE_LED1} !== 2'b11) begin failures++; $display("[TB] FAIL mid_leds got=%b want=11", {TEACHEE_LED0, TEACHEE_LED1}); end
    reset_n = 1'b0;
    tick();
    checks++; if (pending !== 4'b0000) begin failures++; $display("[TB] FAIL mid_rst_pending got=%b want=0000", pending); end
    checks++; if ({TEACHEE_LED0, TEACHEE_LED1} !== 2'b00) begin failures++; $display("[TB] FAIL mid_rst_leds got=%b want=00", {TEACHEE_LED0, TEACHEE_LED1}); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_gvalid got=%b want=0", grant_valid); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("[TB] FAIL mid_rst_gid got=%0d want=0", grant_id); end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    checks++; if ({TEACHEE_LED0, TEACHEE_LED1} !== 2'b01) begin failures++; $display("[TB] FAIL mid_rel_leds got=%b want=01", {TEACHEE_LED0, TEACHEE_LED1}); end
    checks++; if (pending !== 4'b0000) begin failures++; $display("[TB] FAIL mid_rel_pending got=%b want=0000", pending); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rel_gvalid got=%b want=0", grant_valid); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    req_set     = 4'b0000;
    req_pattern = 8'h00;
    btn         = 1'b0;
    test_reset();
    test_idle();
    test_single_fast();
    test_preemption();
    test_button_ack();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
